// File: rtl/mem_access_stage_pkg.sv
// Shared opcode constants, byte-lane geometry and the pending-access record
// for the memory access stage.
package mem_access_stage_pkg;

    localparam int BYTE_LANES = 4;

    // Memory opcodes (MIPS-style primary opcode field)
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // What the stage must remember about an access while it waits for ack
    typedef struct packed {
        logic       is_load;
        logic       is_byte;
        logic       sign_ext;
        logic [1:0] offset;
        logic [4:0] dest;
        logic       reg_write;
    } pend_t;

    function automatic logic is_mem_opcode(input logic [5:0] op);
        return op inside {OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW};
    endfunction

endpackage

// File: rtl/mem_access_stage_byte_lane.sv
// Big-endian byte-lane helper: store-side enables/replication and load-side
// byte extraction with sign or zero extension. Purely combinational.
module mem_byte_lane
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]            st_offset,
    input  logic                  st_byte,
    input  logic [WIDTH-1:0]      st_data,
    output logic [BYTE_LANES-1:0] st_be,
    output logic [WIDTH-1:0]      st_wdata,
    input  logic [1:0]            ld_offset,
    input  logic                  ld_byte,
    input  logic                  ld_signed,
    input  logic [WIDTH-1:0]      ld_rdata,
    output logic [WIDTH-1:0]      ld_data
);

    logic [7:0] ld_sel;

    // Store side: offset 0 is the most significant lane
    always_comb begin
        st_be    = st_byte ? (BYTE_LANES'(4'b1000) >> st_offset) : {BYTE_LANES{1'b1}};
        st_wdata = st_byte ? {BYTE_LANES{st_data[7:0]}} : st_data;
    end

    // Load side: pick the addressed byte and widen it
    always_comb begin
        case (ld_offset)
            2'd0:    ld_sel = ld_rdata[31:24];
            2'd1:    ld_sel = ld_rdata[23:16];
            2'd2:    ld_sel = ld_rdata[15:8];
            default: ld_sel = ld_rdata[7:0];
        endcase
        if (!ld_byte)
            ld_data = ld_rdata;
        else if (ld_signed)
            ld_data = {{(WIDTH-8){ld_sel[7]}}, ld_sel};
        else
            ld_data = {{(WIDTH-8){1'b0}}, ld_sel};
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: issues one data-memory access per load/store with a
// req/ack handshake and bounded wait, passes other results straight through,
// and emits a single registered writeback packet per accepted instruction.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  w_valid_in,
    output logic                  w_ready_out,
    input  logic [5:0]            w_op_code_6,
    input  logic                  w_mem_op,
    input  logic [WIDTH-1:0]      w_alu_result_x,
    input  logic [WIDTH-1:0]      w_store_data_x,
    input  logic [4:0]            w_dest_reg_5,
    input  logic                  w_reg_write,
    output logic                  w_dmem_req,
    output logic                  w_dmem_we,
    output logic [WIDTH-1:0]      w_dmem_addr,
    output logic [WIDTH-1:0]      w_dmem_wdata,
    output logic [BYTE_LANES-1:0] w_dmem_be,
    input  logic [WIDTH-1:0]      w_dmem_rdata,
    input  logic                  w_dmem_ack,
    output logic                  w_wb_valid,
    output logic [WIDTH-1:0]      w_wb_data_x,
    output logic [4:0]            w_wb_dest_5,
    output logic                  w_wb_write,
    output logic                  w_exc_misaligned,
    output logic                  w_exc_bus_error
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_ACCESS = 1'b1;
    localparam int   CNT_W        = $clog2(TIMEOUT + 1);

    logic                  state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [WIDTH-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [BYTE_LANES-1:0] be_q, be_d;
    pend_t                 pend_q, pend_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]      wb_data_q, wb_data_d;
    logic [4:0]            wb_dest_q, wb_dest_d;
    logic                  wb_write_q, wb_write_d;
    logic                  exc_mis_q, exc_mis_d;
    logic                  exc_bus_q, exc_bus_d;

    logic                  accept, mem_kind, word_op, byte_op, misaligned;
    logic                  start_access, ack_hit, timeout_hit;
    logic [BYTE_LANES-1:0] lane_be;
    logic [WIDTH-1:0]      lane_wdata, lane_rdata;

    assign accept       = w_valid_in & w_ready_out;
    // Unknown opcodes flagged as memory-class simply pass through
    assign mem_kind     = w_mem_op & is_mem_opcode(w_op_code_6);
    assign word_op      = (w_op_code_6 == OP_LW) | (w_op_code_6 == OP_SW);
    assign byte_op      = mem_kind & ~word_op;
    assign misaligned   = mem_kind & word_op & (w_alu_result_x[1:0] != 2'b00);
    assign start_access = accept & mem_kind & ~misaligned;
    assign ack_hit      = (state_q == STATE_ACCESS) & w_dmem_ack;
    // Ack takes priority over an expiring wait
    assign timeout_hit  = (state_q == STATE_ACCESS) & ~w_dmem_ack &
                          (cnt_q == CNT_W'(TIMEOUT - 1));

    mem_byte_lane #(.WIDTH(WIDTH)) u_lane (
        .st_offset (w_alu_result_x[1:0]),
        .st_byte   (byte_op),
        .st_data   (w_store_data_x),
        .st_be     (lane_be),
        .st_wdata  (lane_wdata),
        .ld_offset (pend_q.offset),
        .ld_byte   (pend_q.is_byte),
        .ld_signed (pend_q.sign_ext),
        .ld_rdata  (w_dmem_rdata),
        .ld_data   (lane_rdata)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= STATE_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: enter ACCESS on an aligned memory op, leave on ack or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE:   if (start_access) state_d = STATE_ACCESS;
            default:      if (ack_hit || timeout_hit) state_d = STATE_IDLE;
        endcase
    end

    // FSM outputs: upstream stalls exactly while a request is outstanding
    always_comb begin
        w_ready_out = (state_q == STATE_IDLE);
        w_dmem_req  = (state_q == STATE_ACCESS);
    end

    // Datapath next values: bus fields latch only at access start, writeback per completion
    always_comb begin
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        pend_d     = pend_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_dest_d  = wb_dest_q;
        wb_write_d = wb_write_q;
        exc_mis_d  = 1'b0;
        exc_bus_d  = 1'b0;

        if (start_access) begin
            cnt_d            = '0;
            we_d             = (w_op_code_6 == OP_SW) | (w_op_code_6 == OP_SB);
            addr_d           = {w_alu_result_x[WIDTH-1:2], 2'b00};
            wdata_d          = lane_wdata;
            be_d             = lane_be;
            pend_d.is_load   = (w_op_code_6 == OP_LW) | (w_op_code_6 == OP_LB) |
                               (w_op_code_6 == OP_LBU);
            pend_d.is_byte   = byte_op;
            pend_d.sign_ext  = (w_op_code_6 == OP_LB);
            pend_d.offset    = w_alu_result_x[1:0];
            pend_d.dest      = w_dest_reg_5;
            pend_d.reg_write = w_reg_write;
        end else if (state_q == STATE_ACCESS && !w_dmem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept && !start_access) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = w_dest_reg_5;
            if (misaligned) begin
                exc_mis_d  = 1'b1;
                wb_write_d = 1'b0;
                wb_data_d  = '0;
            end else begin
                wb_write_d = w_reg_write;
                wb_data_d  = w_alu_result_x;
            end
        end else if (ack_hit) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = pend_q.dest;
            wb_write_d = pend_q.is_load & pend_q.reg_write;
            wb_data_d  = pend_q.is_load ? lane_rdata : '0;
        end else if (timeout_hit) begin
            wb_valid_d = 1'b1;
            exc_bus_d  = 1'b1;
            wb_dest_d  = pend_q.dest;
            wb_write_d = 1'b0;
            wb_data_d  = '0;
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            pend_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_write_q <= 1'b0;
            exc_mis_q  <= 1'b0;
            exc_bus_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            pend_q     <= pend_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dest_q  <= wb_dest_d;
            wb_write_q <= wb_write_d;
            exc_mis_q  <= exc_mis_d;
            exc_bus_q  <= exc_bus_d;
        end
    end

    assign w_dmem_we        = we_q;
    assign w_dmem_addr      = addr_q;
    assign w_dmem_wdata     = wdata_q;
    assign w_dmem_be        = be_q;
    assign w_wb_valid       = wb_valid_q;
    assign w_wb_data_x      = wb_data_q;
    assign w_wb_dest_5      = wb_dest_q;
    assign w_wb_write       = wb_write_q;
    assign w_exc_misaligned = exc_mis_q;
    assign w_exc_bus_error  = exc_bus_q;

endmodule
